// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes d = a - b - bin, LSB first, one bit per
// cycle. A three-state FSM (IDLE -> SHIFT -> FIN) sequences the operation.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow
// flag output v.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             v
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  // Only WIDTH-1 partial bits are kept; the last diff bit goes straight to d.
  logic [WIDTH-2:0] rs;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a0, b0, dbit, br_nx, last;
  logic [WIDTH-1:0] rs_nx;

  assign a0    = sa[0];
  assign b0    = sb[0];
  assign dbit  = a0 ^ b0 ^ br;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign rs_nx = {dbit, rs};
  assign last  = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == SHIFT);
    done = (state == FIN);
  end

  // Datapath: operand capture, per-bit subtract, result commit on last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      rs   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      v    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          br <= br_nx;
          rs <= rs_nx[WIDTH-1:1];
          if (last) begin
            d    <= rs_nx;
            bout <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB stage vs borrow out of it.
            v    <= br ^ br_nx;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): the driver pushes
// hand-computed expectations, a negedge monitor pops them on each done.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, bout;
  logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic         v;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    string        nm;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, last_done_cyc = -1;
  int b2b = 0, b2b_seen = 0;
  logic prev_done = 1'b0;
  logic [W-1:0] prev_d = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .v(v)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && prev_done) chk("busy_in_idle", busy, 0);
    if (rst_n && done) begin
      exp_t e;
      chk("busy_in_fin", busy, 0);
      if (b2b != 0) begin
        if (b2b_seen > 0) chk("b2b_spacing", cyc - last_done_cyc, W + 2);
        b2b_seen++;
      end
      done_cnt++;
      last_done_cyc = cyc;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got d=%0h expected no done", d);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_d"}, d, e.d);
        chk({e.nm, "_bout"}, bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
        chk({e.nm, "_v"}, v, e.v);
`endif
      end
    end
    prev_done = rst_n && done;
  end

  // Issue one operation from IDLE; returns the accept cycle.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                       input logic [W-1:0] ed, input logic eb, input logic ev,
                       input string nm, output int acc);
    exp_t e;
    e.d = ed; e.bout = eb; e.v = ev; e.nm = nm;
    a = av; b = bv; bin = binv; start = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~binv;   // operands change after acceptance
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_hold_d"}, d, prev_d);
    prev_d = ed;
  endtask

  task automatic wait_done(input int base, input int acc, input string nm);
    int n = 0;
    while (done_cnt == base && n < 3 * W) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == base) chk({nm, "_timeout"}, 0, 1);
    else chk({nm, "_latency"}, last_done_cyc - acc, W);
    @(posedge clk); #1;   // leave FIN, back in IDLE
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout, v;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
    '{8'hC0, 8'h40, 1'b0, 8'h80, 1'b0, 1'b0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, base;
    exp_t e;
    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    repeat (2) @(posedge clk);
    // First start accepted on first edge with reset released
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    e.d = 8'h23; e.bout = 1'b0; e.v = 1'b0; e.nm = "first";
    sbq.push_back(e);
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0; a = 8'hAA; b = 8'h55;
    chk("first_busy", busy, 1);
    prev_d = 8'h23;
    wait_done(0, acc, "first");

    // Directed vectors
    foreach (vecs[i]) begin
      base = done_cnt;
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].v,
            $sformatf("vec%0d", i), acc);
      wait_done(base, acc, $sformatf("vec%0d", i));
    end

    // Start during SHIFT is ignored
    base = done_cnt;
    issue(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "ign", acc);
    repeat (3) @(posedge clk);
    #1; a = 8'h99; b = 8'h44; bin = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    wait_done(base, acc, "ign");
    repeat (W + 4) @(posedge clk);
    #1; chk("ign_single_done", done_cnt - base, 1);

    // Reset mid-SHIFT aborts
    base = done_cnt;
    issue(8'hA5, 8'h11, 1'b0, 8'h94, 1'b0, 1'b0, "abort", acc);
    repeat (3) @(posedge clk);
    #2;
    sbq.delete();
    rst_n = 1'b0;
    #1;
    chk("abort_d", d, 0);
    chk("abort_bout", bout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1; chk("abort_no_done", done_cnt - base, 0);
    prev_d = '0;
    base = done_cnt;
    issue(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, "post_rst", acc);
    wait_done(base, acc, "post_rst");

    // Start held for 30 cycles: accepts at offsets 0, 10, 20
    base = done_cnt;
    b2b = 1;
    e.d = 8'h3B; e.bout = 1'b0; e.v = 1'b0; e.nm = "b2b";
    repeat (3) sbq.push_back(e);
    a = 8'h40; b = 8'h05; bin = 1'b0; start = 1'b1;
    repeat (30) @(posedge clk);
    #1; start = 1'b0;
    for (int n = 0; n < 40 && done_cnt - base < 3; n++) @(posedge clk);
    repeat (W + 4) @(posedge clk);
    #1; chk("b2b_count", done_cnt - base, 3);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
